main_mem_responder: RTL and testbench

//  Lower-level memory model on the miss side of dm_cache. Accepts one block

---
 rtl/main_mem_responder.sv | 120 ++++++++++++
 tb/tb_main_mem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_responder.sv
// Block-granular main-memory model behind dm_cache: one request at a time,
// a fixed DELAY-cycle latency, then the whole block returned with a one-cycle ack.
module main_mem_responder #(
  parameter int ADDR_LENGTH = 10,
  parameter int BLOCK_SIZE  = 4,
  parameter int DELAY       = 50
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_in,
  input  logic                    wr_in,
  input  logic [ADDR_LENGTH-1:0]  addr_in,
  input  logic [8*BLOCK_SIZE-1:0] data_in,
  output logic [8*BLOCK_SIZE-1:0] data_out,
  output logic                    ack_out,
  output logic                    busy_out
);

  localparam int BYTE_SELECT_SIZE = $clog2(BLOCK_SIZE);
  localparam int BLK_W            = ADDR_LENGTH - BYTE_SELECT_SIZE;
  localparam int NUM_BLOCKS       = 2 ** BLK_W;
  localparam int COUNTER_SIZE     = $clog2(DELAY + 1);
  localparam int DATA_W           = 8 * BLOCK_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                  r_state;
  logic [COUNTER_SIZE-1:0] r_counter;
  logic [BLK_W-1:0]        r_blk;
  logic                    r_wr;
  logic [DATA_W-1:0]       r_wdata;
  logic [DATA_W-1:0]       r_data_out;
  logic                    r_ack;
  logic                    r_busy;
  logic [DATA_W-1:0]       r_mem [NUM_BLOCKS];

  logic [BLK_W-1:0]        w_req_blk;
  logic                    w_last_wait;

  // The byte offset selects nothing here: whole blocks move in both directions.
  assign w_req_blk   = addr_in[ADDR_LENGTH-1:BYTE_SELECT_SIZE];
  assign w_last_wait = (r_counter == COUNTER_SIZE'(DELAY - 1));

  generate
    if (BYTE_SELECT_SIZE > 0) begin : g_offset
      logic w_unused_offset;
      assign w_unused_offset = &{1'b0, addr_in[BYTE_SELECT_SIZE-1:0]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_counter  <= '0;
      r_blk      <= '0;
      r_wr       <= 1'b0;
      r_wdata    <= '0;
      r_data_out <= '0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      // NOTE: the memory is cleared on reset because the model must read back
      // zeros afterwards; a real SRAM macro could not do this.
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      // NOTE: all state updates are non-blocking so every register samples
      // the pre-edge values of the others.
      case (r_state)
        ST_IDLE: begin
          if (req_in) begin
            r_blk     <= w_req_blk;
            r_wr      <= wr_in;
            r_wdata   <= data_in;
            r_counter <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          // Inputs are ignored here; only the latched request is used.
          if (w_last_wait) begin
            r_state <= ST_RESP;
            r_ack   <= 1'b1;
            if (r_wr) begin
              r_mem[r_blk] <= r_wdata;
              r_data_out   <= r_wdata;
            end else begin
              r_data_out <= r_mem[r_blk];
            end
          end else begin
            r_counter <= r_counter + COUNTER_SIZE'(1);
          end
        end

        ST_RESP: begin
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_out = r_data_out;
  assign ack_out  = r_ack;
  assign busy_out = r_busy;

endmodule

// File: tb/tb_main_mem_responder.sv
// Randomised scoreboard bench for main_mem_responder: a block-array reference
// model predicts each response; monitors pop and compare whenever ack_out fires.
module tb_main_mem_responder;

  localparam int D = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_in, wr_in;
  logic [9:0]  addr_in;
  logic [31:0] data_in, data_out;
  logic        ack_out, busy_out;

  logic        req1, wr1;
  logic [9:0]  addr1;
  logic [31:0] data1, dout1;
  logic        ack1, busy1;

  always #5 clk = ~clk;

  main_mem_responder #(.ADDR_LENGTH(10), .BLOCK_SIZE(4), .DELAY(D)) u_dut (
    .clk(clk), .reset(reset), .req_in(req_in), .wr_in(wr_in), .addr_in(addr_in),
    .data_in(data_in), .data_out(data_out), .ack_out(ack_out), .busy_out(busy_out)
  );

  main_mem_responder #(.ADDR_LENGTH(10), .BLOCK_SIZE(4), .DELAY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_in(req1), .wr_in(wr1), .addr_in(addr1),
    .data_in(data1), .data_out(dout1), .ack_out(ack1), .busy_out(busy1)
  );

  // Posedge count: read at a negedge it names the edge that just passed.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          ack_cyc;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        sb1[$];
  logic [31:0] mm  [256];
  logic [31:0] mm1 [256];

  task automatic clear_models();
    for (int i = 0; i < 256; i++) begin
      mm[i]  = '0;
      mm1[i] = '0;
    end
  endtask

  // Monitors: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ack_out === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ack: ack_out=1 at edge %0d with nothing outstanding", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, " data"}, data_out, e.data);
        check({e.tag, " ack_edge"}, cyc, e.ack_cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (ack1 === 1'b1) begin
      if (sb1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ack_d1: ack_out=1 at edge %0d with nothing outstanding", cyc);
      end else begin
        exp_t e;
        e = sb1.pop_front();
        check({e.tag, " data"}, dout1, e.data);
        check({e.tag, " ack_edge"}, cyc, e.ack_cyc);
      end
    end
  end

  // Called at a negedge. With hold=1, req_in stays high through the ack and a
  // second (read) transaction to the same block is expected.
  task automatic txn(input string tag, input bit wr, input logic [9:0] addr,
                     input logic [31:0] data, input bit hold);
    int   e0;
    int   n;
    exp_t e;
    req_in  = 1'b1;
    wr_in   = wr;
    addr_in = addr;
    data_in = data;
    @(negedge clk);
    e0 = cyc;
    e.tag     = tag;
    e.ack_cyc = e0 + D;
    if (wr) begin
      mm[addr / 4] = data;
      e.data       = data;
    end else begin
      e.data = mm[addr / 4];
    end
    sb.push_back(e);
    if (!hold) req_in = 1'b0;
    n = 0;
    while (busy_out === 1'b1 && n < 200) begin
      n++;
      if (!hold) begin
        wr_in   = 1'b1;
        addr_in = n[0] ? 10'h100 : 10'($urandom);
        data_in = $urandom;
      end
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, n, D + 1);
    if (hold) begin
      wr_in     = 1'b0;
      e.tag     = {tag, " second"};
      e.data    = mm[addr / 4];
      e.ack_cyc = cyc + 1 + D;
      sb.push_back(e);
      @(negedge clk);
      req_in = 1'b0;
      check({tag, " busy_after_gap"}, busy_out, 1'b1);
      n = 0;
      while (busy_out === 1'b1 && n < 200) begin
        n++;
        @(negedge clk);
      end
      check({tag, " second_busy_cycles"}, n, D + 1);
    end
  endtask

  task automatic txn1(input string tag, input bit wr, input logic [9:0] addr,
                      input logic [31:0] data);
    int   n;
    exp_t e;
    req1  = 1'b1;
    wr1   = wr;
    addr1 = addr;
    data1 = data;
    @(negedge clk);
    req1      = 1'b0;
    e.tag     = tag;
    e.ack_cyc = cyc + 1;
    if (wr) begin
      mm1[addr / 4] = data;
      e.data        = data;
    end else begin
      e.data = mm1[addr / 4];
    end
    sb1.push_back(e);
    n = 0;
    while (busy1 === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, n, 2);
  endtask

  initial begin
    reset   = 1'b1;
    req_in  = 1'b0;
    wr_in   = 1'b0;
    addr_in = '0;
    data_in = '0;
    req1    = 1'b0;
    wr1     = 1'b0;
    addr1   = '0;
    data1   = '0;
    clear_models();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset data_out", data_out, 32'h0);
    check("reset ack_out", ack_out, 1'b0);
    check("reset busy_out", busy_out, 1'b0);
    check("reset d1 data_out", dout1, 32'h0);
    @(negedge clk);

    txn("t1 read 032", 1'b0, 10'h032, 32'h0, 1'b0);
    txn("t2 write 034", 1'b1, 10'h034, 32'hDEADBEEF, 1'b0);
    txn("t2 read 037", 1'b0, 10'h037, 32'h0, 1'b0);
    txn("t3 write 3FC", 1'b1, 10'h3FC, 32'h12345678, 1'b0);
    txn("t3 read 000", 1'b0, 10'h000, 32'h0, 1'b0);
    txn("t3 read 3FD", 1'b0, 10'h3FD, 32'h0, 1'b0);
    txn("t4 read 034", 1'b0, 10'h034, 32'h0, 1'b0);
    txn("t4 read 100", 1'b0, 10'h100, 32'h0, 1'b0);

    // Abort a write partway through WAIT; nothing may be acked or committed.
    req_in  = 1'b1;
    wr_in   = 1'b1;
    addr_in = 10'h040;
    data_in = 32'hCAFEF00D;
    @(negedge clk);
    req_in = 1'b0;
    repeat (20) @(negedge clk);
    check("t5 busy mid_wait", busy_out, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_models();
    check("t5 busy after reset", busy_out, 1'b0);
    check("t5 ack after reset", ack_out, 1'b0);
    check("t5 data after reset", data_out, 32'h0);
    repeat (D + 5) @(negedge clk);
    txn("t5 read 040", 1'b0, 10'h040, 32'h0, 1'b0);

    txn("t6 hold", 1'b1, 10'h2A0, 32'hA5A5_1234, 1'b1);

    txn1("t7 d1 read 010", 1'b0, 10'h010, 32'h0);
    txn1("t7 d1 write 010", 1'b1, 10'h010, 32'h0BAD_F00D);
    txn1("t7 d1 read 013", 1'b0, 10'h013, 32'h0);
    for (int i = 0; i < 6; i++) begin
      txn1($sformatf("t7 d1 rand%0d", i), 1'($urandom), 10'($urandom_range(0, 31)), $urandom);
    end

    for (int i = 0; i < 14; i++) begin
      txn($sformatf("rand%0d", i), 1'($urandom), {5'($urandom_range(0, 3)), 5'($urandom)},
          $urandom, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);
    check("scoreboard d1 drained", sb1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
